comp_slot_buf: RTL and testbench

Per-thread computation buffer with slot-state tracking for the sha512crypt unit. Each thread owns one slot holding a computation's data1 (read by the block-transmission side) and data2 (read by the memory-input side). Unlike a bare dual-read RAM, every slot carries its own lifecycle: a slot is loaded once, each consumer reads and releases its half independently, and the slot returns to free only when both halves are released. Free and pending masks let the thread scheduler and both consumers arbitrate without extra bookkeeping.

---
 rtl/comp_slot_buf_if.sv | 48 ++++
 rtl/comp_slot_buf.sv | 111 +++++++++++
 tb/tb_comp_slot_buf.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/comp_slot_buf_if.sv
// Request/response bundle for comp_slot_buf: slot load, release, dual read and status.
// The master (thread scheduler side) drives requests; the slave (buffer) returns data and masks.
interface comp_slot_buf_if #(
    parameter int N_THREADS   = 16,
    parameter int DATA1_WIDTH = 64,
    parameter int DATA2_WIDTH = 64
);
    localparam int N_THREADS_MSB = $clog2(N_THREADS) - 1;

    logic [N_THREADS_MSB:0] wr_thread_num;
    logic                   wr_en;
    logic [DATA1_WIDTH-1:0] wr_data1;
    logic [DATA2_WIDTH-1:0] wr_data2;

    logic [N_THREADS_MSB:0] rd_thread_num1;
    logic [N_THREADS_MSB:0] rd_thread_num2;
    logic [DATA1_WIDTH-1:0] dout1;
    logic [DATA2_WIDTH-1:0] dout2;
    logic                   dout1_valid;
    logic                   dout2_valid;

    logic                   done1;
    logic                   done2;
    logic [N_THREADS_MSB:0] done_thread_num1;
    logic [N_THREADS_MSB:0] done_thread_num2;

    logic [N_THREADS-1:0]   free_mask;
    logic [N_THREADS-1:0]   pend1_mask;
    logic [N_THREADS-1:0]   pend2_mask;
    logic                   err_wr;
    logic                   err_parity;

    modport master (
        output wr_thread_num, wr_en, wr_data1, wr_data2,
        output rd_thread_num1, rd_thread_num2,
        output done1, done2, done_thread_num1, done_thread_num2,
        input  dout1, dout2, dout1_valid, dout2_valid,
        input  free_mask, pend1_mask, pend2_mask, err_wr, err_parity
    );

    modport slave (
        input  wr_thread_num, wr_en, wr_data1, wr_data2,
        input  rd_thread_num1, rd_thread_num2,
        input  done1, done2, done_thread_num1, done_thread_num2,
        output dout1, dout2, dout1_valid, dout2_valid,
        output free_mask, pend1_mask, pend2_mask, err_wr, err_parity
    );
endinterface

// File: rtl/comp_slot_buf.sv
// Per-thread computation buffer: each slot holds data1/data2 released independently by two consumers.
// Optional feature: define COMP_SLOT_BUF_PARITY_EN for per-half even parity with a sticky err_parity.
module comp_slot_buf #(
    parameter int N_THREADS   = 16,
    parameter int DATA1_WIDTH = 64,
    parameter int DATA2_WIDTH = 64
) (
    input logic             CLK,
    input logic             RESET_N,
    comp_slot_buf_if.slave  bus
);
    localparam int N_THREADS_MSB = $clog2(N_THREADS) - 1;

    logic [N_THREADS-1:0]   pend1_q, pend1_d;
    logic [N_THREADS-1:0]   pend2_q, pend2_d;
    logic                   err_wr_q, err_wr_d;
    logic                   wr_ok;

    logic [DATA1_WIDTH-1:0] mem1_q [N_THREADS];
    logic [DATA2_WIDTH-1:0] mem2_q [N_THREADS];
    logic [DATA1_WIDTH-1:0] dout1_q;
    logic [DATA2_WIDTH-1:0] dout2_q;
    logic                   dout1_valid_q;
    logic                   dout2_valid_q;

    // A load is only accepted into a slot that is fully free before this edge.
    assign wr_ok = bus.wr_en
                 && !pend1_q[bus.wr_thread_num]
                 && !pend2_q[bus.wr_thread_num];

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        pend1_d  = pend1_q;
        pend2_d  = pend2_q;
        err_wr_d = err_wr_q | (bus.wr_en & ~wr_ok);
        if (bus.done1) pend1_d[bus.done_thread_num1] = 1'b0;
        if (bus.done2) pend2_d[bus.done_thread_num2] = 1'b0;
        if (wr_ok) begin
            pend1_d[bus.wr_thread_num] = 1'b1;
            pend2_d[bus.wr_thread_num] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pend1_q       <= '0;
            pend2_q       <= '0;
            err_wr_q      <= 1'b0;
            dout1_q       <= '0;
            dout2_q       <= '0;
            dout1_valid_q <= 1'b0;
            dout2_valid_q <= 1'b0;
        end else begin
            pend1_q       <= pend1_d;
            pend2_q       <= pend2_d;
            err_wr_q      <= err_wr_d;
            dout1_q       <= mem1_q[bus.rd_thread_num1];
            dout2_q       <= mem2_q[bus.rd_thread_num2];
            dout1_valid_q <= pend1_q[bus.rd_thread_num1];
            dout2_valid_q <= pend2_q[bus.rd_thread_num2];
        end
    end

    // NOTE: storage is left unreset so it maps to distributed RAM; validity lives in pend bits.
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem1_q[bus.wr_thread_num] <= bus.wr_data1;
            mem2_q[bus.wr_thread_num] <= bus.wr_data2;
        end
    end

`ifdef COMP_SLOT_BUF_PARITY_EN
    logic                 par1_q [N_THREADS];
    logic                 par2_q [N_THREADS];
    logic                 err_parity_q;
    logic                 par1_bad;
    logic                 par2_bad;

    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            par1_q[bus.wr_thread_num] <= ^bus.wr_data1;
            par2_q[bus.wr_thread_num] <= ^bus.wr_data2;
        end
    end

    // Only reads that will be presented as valid are checked; free slots hold junk.
    assign par1_bad = pend1_q[bus.rd_thread_num1]
                    && ((^mem1_q[bus.rd_thread_num1]) != par1_q[bus.rd_thread_num1]);
    assign par2_bad = pend2_q[bus.rd_thread_num2]
                    && ((^mem2_q[bus.rd_thread_num2]) != par2_q[bus.rd_thread_num2]);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) err_parity_q <= 1'b0;
        else if (par1_bad || par2_bad) err_parity_q <= 1'b1;
    end

    assign bus.err_parity = err_parity_q;
`else
    assign bus.err_parity = 1'b0;
`endif

    assign bus.dout1       = dout1_q;
    assign bus.dout2       = dout2_q;
    assign bus.dout1_valid = dout1_valid_q;
    assign bus.dout2_valid = dout2_valid_q;
    assign bus.free_mask   = ~(pend1_q | pend2_q);
    assign bus.pend1_mask  = pend1_q;
    assign bus.pend2_mask  = pend2_q;
    assign bus.err_wr      = err_wr_q;

endmodule

// File: tb/tb_comp_slot_buf.sv
// Scoreboard bench for comp_slot_buf: stimulus pushes expected post-edge state, a monitor pops and compares.
module tb_comp_slot_buf;
    localparam int N  = 16;
    localparam int W1 = 64;
    localparam int W2 = 64;

    localparam logic [W1-1:0] D1A = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [W2-1:0] D2A = 64'h5A5A_5A5A_5A5A_5A5A;
    localparam logic [W1-1:0] D1B = 64'h1111_2222_3333_4444;
    localparam logic [W2-1:0] D2B = 64'h5555_6666_7777_8888;
    localparam logic [W1-1:0] D1C = 64'hDEAD_BEEF_0000_0001;
    localparam logic [W2-1:0] D2C = 64'hCAFE_F00D_0000_0002;
    localparam logic [W1-1:0] D1D = 64'h0123_4567_89AB_CDEF;
    localparam logic [W2-1:0] D2D = 64'hFEDC_BA98_7654_3210;

    typedef struct {
        int              tag;
        bit              c1;
        logic [W1-1:0]   d1;
        bit              v1;
        bit              c2;
        logic [W2-1:0]   d2;
        bit              v2;
        logic [N-1:0]    fm;
        logic [N-1:0]    p1;
        logic [N-1:0]    p2;
        bit              ew;
        bit              ep;
    } exp_t;

    logic CLK;
    logic RESET_N;
    int   checks = 0;
    int   errors = 0;
    bit   obs_en = 0;
    bit   obs_pipe = 0;
    exp_t exp_q[$];

    comp_slot_buf_if #(.N_THREADS(N), .DATA1_WIDTH(W1), .DATA2_WIDTH(W2)) bus ();

    comp_slot_buf #(.N_THREADS(N), .DATA1_WIDTH(W1), .DATA2_WIDTH(W2)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input int tag, input string what, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s tag=%0d got %h want %h", what, tag, act, want);
        end
    endtask

    function automatic exp_t mk(input int tag,
                                input bit c1, input logic [W1-1:0] d1, input bit v1,
                                input bit c2, input logic [W2-1:0] d2, input bit v2,
                                input logic [N-1:0] p1, input logic [N-1:0] p2,
                                input bit ew, input bit ep);
        exp_t e;
        e.tag = tag; e.c1 = c1; e.d1 = d1; e.v1 = v1;
        e.c2 = c2; e.d2 = d2; e.v2 = v2;
        e.p1 = p1; e.p2 = p2; e.fm = ~(p1 | p2);
        e.ew = ew; e.ep = ep;
        return e;
    endfunction

    always @(posedge CLK) obs_pipe <= obs_en;

    // Monitor: each observed cycle is compared just after the edge that produced it.
    always @(negedge CLK) begin
        if (obs_pipe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard underflow at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.tag, "dout1_valid", 64'(bus.dout1_valid), 64'(e.v1));
                check(e.tag, "dout2_valid", 64'(bus.dout2_valid), 64'(e.v2));
                if (e.c1) check(e.tag, "dout1", bus.dout1, e.d1);
                if (e.c2) check(e.tag, "dout2", bus.dout2, e.d2);
                check(e.tag, "free_mask", 64'(bus.free_mask), 64'(e.fm));
                check(e.tag, "pend1_mask", 64'(bus.pend1_mask), 64'(e.p1));
                check(e.tag, "pend2_mask", 64'(bus.pend2_mask), 64'(e.p2));
                check(e.tag, "err_wr", 64'(bus.err_wr), 64'(e.ew));
                check(e.tag, "err_parity", 64'(bus.err_parity), 64'(e.ep));
            end
        end
    end

    task automatic idle_inputs();
        bus.wr_en = 1'b0;
        bus.done1 = 1'b0;
        bus.done2 = 1'b0;
    endtask

    // One clock: inputs already set by caller, expectation (if any) describes state after the edge.
    task automatic cyc(input bit obs, input exp_t e);
        if (obs) exp_q.push_back(e);
        obs_en = obs;
        @(posedge CLK);
        #1;
        obs_en = 1'b0;
        idle_inputs();
    endtask

    task automatic wr(input int slot, input logic [W1-1:0] d1, input logic [W2-1:0] d2);
        bus.wr_en = 1'b1;
        bus.wr_thread_num = 4'(slot);
        bus.wr_data1 = d1;
        bus.wr_data2 = d2;
    endtask

    task automatic rd(input int s1, input int s2);
        bus.rd_thread_num1 = 4'(s1);
        bus.rd_thread_num2 = 4'(s2);
    endtask

    task automatic check_reset_state(input int tag);
        check(tag, "rst free_mask", 64'(bus.free_mask), 64'(16'hFFFF));
        check(tag, "rst pend1_mask", 64'(bus.pend1_mask), 64'h0);
        check(tag, "rst pend2_mask", 64'(bus.pend2_mask), 64'h0);
        check(tag, "rst dout1", bus.dout1, 64'h0);
        check(tag, "rst dout2", bus.dout2, 64'h0);
        check(tag, "rst dout1_valid", 64'(bus.dout1_valid), 64'h0);
        check(tag, "rst dout2_valid", 64'(bus.dout2_valid), 64'h0);
        check(tag, "rst err_wr", 64'(bus.err_wr), 64'h0);
        check(tag, "rst err_parity", 64'(bus.err_parity), 64'h0);
    endtask

    exp_t nx;

    initial begin
        logic [N-1:0] pend;
        RESET_N = 1'b0;
        idle_inputs();
        bus.wr_thread_num = '0;
        bus.wr_data1 = '0;
        bus.wr_data2 = '0;
        bus.done_thread_num1 = '0;
        bus.done_thread_num2 = '0;
        rd(0, 0);
        nx = mk(0, 0, '0, 0, 0, '0, 0, '0, '0, 0, 0);

        repeat (2) @(posedge CLK);
        #1;
        check_reset_state(0);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;

        // Load slot 3; same-cycle read sees the old (free) state.
        wr(3, D1A, D2A); rd(3, 3);
        cyc(1, mk(1, 0, '0, 0, 0, '0, 0, 16'h0008, 16'h0008, 0, 0));
        cyc(1, mk(2, 1, D1A, 1, 1, D2A, 1, 16'h0008, 16'h0008, 0, 0));

        // Release data1 first, data2 two cycles later.
        bus.done1 = 1'b1; bus.done_thread_num1 = 4'd3;
        cyc(1, mk(3, 1, D1A, 1, 1, D2A, 1, 16'h0000, 16'h0008, 0, 0));
        cyc(1, mk(4, 0, '0, 0, 1, D2A, 1, 16'h0000, 16'h0008, 0, 0));
        bus.done2 = 1'b1; bus.done_thread_num2 = 4'd3;
        cyc(1, mk(5, 0, '0, 0, 1, D2A, 1, 16'h0000, 16'h0000, 0, 0));
        cyc(1, mk(6, 0, '0, 0, 0, '0, 0, 16'h0000, 16'h0000, 0, 0));

        // Double load of slot 5: second write rejected, err_wr sticks.
        wr(5, D1B, D2B); rd(5, 5);
        cyc(1, mk(7, 0, '0, 0, 0, '0, 0, 16'h0020, 16'h0020, 0, 0));
        wr(5, D1C, D2C);
        cyc(1, mk(8, 1, D1B, 1, 1, D2B, 1, 16'h0020, 16'h0020, 1, 0));
        cyc(1, mk(9, 1, D1B, 1, 1, D2B, 1, 16'h0020, 16'h0020, 1, 0));

        // Slot 7: full release and write in the same cycle -> write rejected, slot freed.
        wr(7, D1A, D2A); rd(7, 7);
        cyc(1, mk(10, 0, '0, 0, 0, '0, 0, 16'h00A0, 16'h00A0, 1, 0));
        wr(7, D1C, D2C);
        bus.done1 = 1'b1; bus.done_thread_num1 = 4'd7;
        bus.done2 = 1'b1; bus.done_thread_num2 = 4'd7;
        cyc(1, mk(11, 1, D1A, 1, 1, D2A, 1, 16'h0020, 16'h0020, 1, 0));
        wr(7, D1D, D2D);
        cyc(1, mk(12, 1, D1A, 0, 1, D2A, 0, 16'h00A0, 16'h00A0, 1, 0));
        cyc(1, mk(13, 1, D1D, 1, 1, D2D, 1, 16'h00A0, 16'h00A0, 1, 0));

        // Fill every slot; slots 5 and 7 are already busy.
        pend = 16'h00A0;
        for (int i = 0; i < N; i++) begin
            wr(i, 64'(i), 64'(i + 100));
            pend[i] = 1'b1;
            cyc(1, mk(20 + i, 1, D1D, 1, 1, D2D, 1, pend, pend, 1, 0));
        end
        check(40, "all loaded free_mask", 64'(bus.free_mask), 64'h0);
        cyc(0, nx);

        // Asynchronous reset mid-cycle.
        #3;
        RESET_N = 1'b0;
        #1;
        check_reset_state(41);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;

        // Operation resumes after reset; slot 2 reload and read back.
        wr(2, D1B, D2C); rd(2, 2);
        cyc(1, mk(50, 0, '0, 0, 0, '0, 0, 16'h0004, 16'h0004, 0, 0));
`ifdef COMP_SLOT_BUF_PARITY_EN
        tb_comp_slot_buf.dut.mem1_q[2] = tb_comp_slot_buf.dut.mem1_q[2] ^ 64'h1;
        cyc(1, mk(51, 1, D1B ^ 64'h1, 1, 1, D2C, 1, 16'h0004, 16'h0004, 0, 1));
`else
        cyc(1, mk(51, 1, D1B, 1, 1, D2C, 1, 16'h0004, 16'h0004, 0, 0));
`endif
        cyc(0, nx);
        cyc(0, nx);

        check(60, "scoreboard drained", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
